// File: rtl/mod_reduce_seq_ctrl_pkg.sv
// Shared constants, state encoding and modular-add helper for the mod-113 reduction sequencer.
package mod113_pkg;

    localparam int unsigned MOD     = 113;
    localparam int unsigned IN_W    = 200;
    localparam int unsigned CHUNK_W = 6;
    localparam int unsigned RES_W   = 7;
    localparam int unsigned NCHUNK  = (IN_W + CHUNK_W - 1) / CHUNK_W;
    localparam int unsigned IDX_W   = $clog2(NCHUNK);
    localparam int unsigned PAD_W   = NCHUNK * CHUNK_W;

    localparam logic [RES_W-1:0] MOD_R = RES_W'(MOD);
    localparam logic [RES_W:0]   MOD_S = (RES_W + 1)'(MOD);

    typedef logic [IN_W-1:0]  operand_t;
    typedef logic [RES_W-1:0] residue_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One conditional subtract keeps the sum in 0..MOD-1 when both inputs already are.
    function automatic residue_t modadd(input residue_t a, input residue_t b);
        logic [RES_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= MOD_S) begin
            s = s - MOD_S;
        end
        return s[RES_W-1:0];
    endfunction

endpackage

// File: rtl/mod_reduce_seq_ctrl_if.sv
// Operand-in / residue-out valid-ready bundle of the reduction sequencer.
interface mod_reduce_seq_ctrl_if import mod113_pkg::*; ();

    logic     in_valid;
    logic     in_ready;
    operand_t in_x;
    logic     out_valid;
    logic     out_ready;
    residue_t out_res;

    modport master (
        output in_valid,
        output in_x,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_res
    );

    modport slave (
        input  in_valid,
        input  in_x,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_res
    );

endinterface

// File: rtl/mod_reduce_seq_ctrl_acc.sv
// Combinational accumulate step: folds one LUT residue into the running sum modulo MOD.
module mod_acc_add import mod113_pkg::*; (
    input  residue_t acc,
    input  residue_t lut_z,
    output residue_t sum_c,
    output logic     lut_bad_c
);

    residue_t z_fix;

    // An out-of-range table entry is folded once so the sum stays in range.
    always_comb begin
        lut_bad_c = (lut_z >= MOD_R);
        z_fix     = lut_bad_c ? residue_t'(lut_z - MOD_R) : lut_z;
        sum_c     = modadd(acc, z_fix);
    end

endmodule

// File: rtl/mod_reduce_seq_ctrl.sv
// Walks a wide operand chunk by chunk through an external residue LUT bank and returns X mod MOD.
module mod_reduce_seq_ctrl import mod113_pkg::*; (
    input  logic                    clk,
    input  logic                    rst,
    mod_reduce_seq_ctrl_if.slave    bus,
    output logic [IDX_W-1:0]        lut_sel,
    output logic [CHUNK_W-1:0]      lut_x,
    input  residue_t                lut_z,
    output logic                    busy,
    output logic                    lut_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    residue_t           acc_q, acc_d;
    logic [PAD_W-1:0]   opnd_q, opnd_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    residue_t           out_res_q, out_res_d;
    logic               busy_q, busy_d;
    logic               lut_err_q, lut_err_d;

    residue_t           sum_c;
    logic               lut_bad_c;

    mod_acc_add u_acc (
        .acc       (acc_q),
        .lut_z     (lut_z),
        .sum_c     (sum_c),
        .lut_bad_c (lut_bad_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            busy_q      <= 1'b0;
            lut_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            busy_q      <= busy_d;
            lut_err_q   <= lut_err_d;
        end
    end

    // Next-state and next-output logic; handshake outputs are decoded from the next state.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        out_res_d   = out_res_q;
        lut_err_d   = lut_err_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = RUN;
                    opnd_d  = PAD_W'(bus.in_x);
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            RUN: begin
                acc_d  = sum_c;
                // The operand shifts down so chunk idx is always in the low bits; it drains to zero.
                opnd_d = opnd_q >> CHUNK_W;
                if (lut_bad_c) begin
                    lut_err_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d   = DONE;
                    idx_d     = '0;
                    out_res_d = sum_c;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_res   = out_res_q;
    assign busy          = busy_q;
    assign lut_err       = lut_err_q;
    // idx and the shifted operand are both zero outside RUN, so the bank sees 0/0 there.
    assign lut_sel       = idx_q;
    assign lut_x         = opnd_q[CHUNK_W-1:0];

endmodule

// File: tb/tb_mod_reduce_seq_ctrl.sv
// Randomized self-checking bench for mod_reduce_seq_ctrl against an arithmetic reference model.
module tb_mod_reduce_seq_ctrl;
    import mod113_pkg::*;

    localparam int M = int'(MOD);

    logic               clk;
    logic               rst;
    logic [IDX_W-1:0]   lut_sel;
    logic [CHUNK_W-1:0] lut_x;
    residue_t           lut_z;
    logic               busy;
    logic               lut_err;

    int total = 0;
    int bad   = 0;

    bit mon_en    = 1'b0;
    bit force_en  = 1'b0;
    int force_idx = 0;
    int force_val = 0;

    mod_reduce_seq_ctrl_if bus ();

    mod_reduce_seq_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .lut_sel (lut_sel),
        .lut_x   (lut_x),
        .lut_z   (lut_z),
        .busy    (busy),
        .lut_err (lut_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table X_k: (x * 64^k) mod 113.
    function automatic int lut_ref(input int xv, input int k);
        int p;
        p = 1;
        for (int i = 0; i < k; i++) p = (p * 64) % M;
        return (xv * p) % M;
    endfunction

    // Bit-serial Horner reduction of the whole operand.
    function automatic int ref_mod(input operand_t x);
        int r;
        r = 0;
        for (int i = IN_W - 1; i >= 0; i--) r = (r * 2 + int'(x[i])) % M;
        return r;
    endfunction

    function automatic operand_t rand_x();
        logic [223:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 7) == 0) t = t & 224'hFFFF_FFFF;
        return t[IN_W-1:0];
    endfunction

    always_comb begin
        if (force_en && int'(lut_sel) == force_idx) lut_z = RES_W'(force_val);
        else lut_z = RES_W'(lut_ref(int'(lut_x), int'(lut_sel)));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) chk("rdy_while_busy", 32'(bus.in_ready & busy), 32'd0);
    end

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_lut_sel"}, 32'(lut_sel), 32'd0);
        chk({tag, "_lut_x"}, 32'(lut_x), 32'd0);
    endtask

    // Offer x and return just after the accepting edge.
    task automatic send(input operand_t x);
        int n;
        n = 0;
        bus.in_x     = x;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            step();
            n++;
        end
        if (!bus.in_ready) chk("accept_timeout", 32'd1, 32'd0);
        step();
        bus.in_valid = 1'b0;
    endtask

    // lat counts cycles from the accept cycle to the first cycle out_valid is seen.
    task automatic recv(input int gap, input bit rand_rdy, output residue_t res, output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            lat++;
        end
        res = bus.out_res;
        if (!bus.out_valid) begin
            chk("result_timeout", 32'd0, 32'd1);
            bus.out_ready = 1'b0;
            return;
        end
        for (int i = 0; i < gap; i++) begin
            bus.out_ready = 1'b0;
            step();
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_res", 32'(bus.out_res), 32'(res));
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("pop_valid", 32'(bus.out_valid), 32'd0);
        chk("pop_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        operand_t x, y;
        operand_t vec [4];
        int       exp_v [4];
        residue_t res;
        int       lat, n, e;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_idle("reset");
        chk("reset_out_res", 32'(bus.out_res), 32'd0);
        chk("reset_lut_err", 32'(lut_err), 32'd0);

        // T1: zero operand and fixed latency
        send('0);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_in_ready", 32'(bus.in_ready), 32'd0);
        recv(0, 1'b0, res, lat);
        chk("t1_res", 32'(res), 32'd0);
        chk("t1_latency", 32'(lat), 32'(NCHUNK + 1));
        chk("t1_lut_err", 32'(lut_err), 32'd0);

        // T2: directed boundary operands
        vec[0] = operand_t'(113); exp_v[0] = 0;
        vec[1] = operand_t'(1);   exp_v[1] = 1;
        vec[2] = '0; vec[2][IN_W-1] = 1'b1; exp_v[2] = 8;
        vec[3] = '1;              exp_v[3] = 15;
        for (int i = 0; i < 4; i++) begin
            send(vec[i]);
            recv(1, 1'b0, res, lat);
            chk("t2_res", 32'(res), 32'(exp_v[i]));
            chk("t2_latency", 32'(lat), 32'(NCHUNK + 1));
        end

        // T3: random operands with random handshake gaps
        mon_en = 1'b1;
        for (int i = 0; i < 500; i++) begin
            repeat ($urandom_range(0, 3)) step();
            x = rand_x();
            send(x);
            recv($urandom_range(0, 3), 1'b1, res, lat);
            chk("t3_res", 32'(res), 32'(ref_mod(x)));
        end
        chk("t3_lut_err", 32'(lut_err), 32'd0);

        // T4: backpressure in DONE while a new operand is offered
        x = rand_x();
        y = rand_x();
        send(x);
        n = 1;
        while (!bus.out_valid && n < 100) begin
            step();
            n++;
        end
        res = bus.out_res;
        chk("t4_res", 32'(res), 32'(ref_mod(x)));
        bus.in_x = y;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'(i & 1);
            step();
            chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("t4_hold_res", 32'(bus.out_res), 32'(res));
            chk("t4_no_accept", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("t4_pop_valid", 32'(bus.out_valid), 32'd0);
        chk("t4_pop_busy", 32'(busy), 32'd0);
        chk("t4_pop_ready", 32'(bus.in_ready), 32'd1);
        send(y);
        recv(0, 1'b0, res, lat);
        chk("t4_next_res", 32'(res), 32'(ref_mod(y)));
        mon_en = 1'b0;

        // T5: reset in the middle of RUN
        send(rand_x());
        n = 0;
        while (int'(lut_sel) != 17 && n < 100) begin
            step();
            n++;
        end
        chk("t5_reached_idx", 32'(lut_sel), 32'd17);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("t5_after_rst");
        chk("t5_out_res", 32'(bus.out_res), 32'd0);
        n = 0;
        repeat (40) begin
            step();
            if (bus.out_valid) n++;
        end
        chk("t5_no_pulse", 32'(n), 32'd0);
        send(operand_t'(114));
        recv(0, 1'b0, res, lat);
        chk("t5_res", 32'(res), 32'd1);

        // T6: out-of-range LUT entry sets a sticky error
        x = rand_x();
        force_en  = 1'b1;
        force_idx = 5;
        force_val = 120;
        send(x);
        recv(0, 1'b0, res, lat);
        force_en = 1'b0;
        e = (ref_mod(x) - lut_ref(int'(x[35:30]), 5) + (120 - M) + M) % M;
        chk("t6_res", 32'(res), 32'(e));
        chk("t6_lut_err", 32'(lut_err), 32'd1);
        y = rand_x();
        send(y);
        recv(2, 1'b0, res, lat);
        chk("t6_next_res", 32'(res), 32'(ref_mod(y)));
        chk("t6_err_sticky", 32'(lut_err), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_err_cleared", 32'(lut_err), 32'd0);
        check_idle("t6_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
